// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-pulse memory request interface between fetch (port 0) and load/store (port 1)
module mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int STRB_WIDTH    = DATA_WIDTH/8,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  p0_req,
  input  logic                  p1_req,
  input  logic                  p0_wen,
  input  logic                  p1_wen,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic [STRB_WIDTH-1:0] p0_wstrb,
  input  logic [STRB_WIDTH-1:0] p1_wstrb,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p0_ready,
  output logic                  p1_ready,
  output logic                  mem_req,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  input  logic                  mem_busy,
  output logic                  grant,
  output logic                  arb_busy
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic   last_grant;
  logic   win;
  assign arb_busy = state != IDLE;
  // winner if an issue happens this cycle: port 0 first in fixed mode, otherwise a tie goes to the port not served last
  always_comb
    win = (PRIORITY_MODE != 0) ? !p0_req : ((p0_req && p1_req) ? !last_grant : p1_req);
  // issue/wait/complete sequencing with every output registered
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      mem_req    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      p0_ready   <= 1'b0;
      p1_ready   <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      case (state)
        IDLE: if ((p0_req || p1_req) && !mem_busy) begin
          mem_wen    <= win ? p1_wen : p0_wen;
          mem_addr   <= win ? p1_addr : p0_addr;
          mem_wdata  <= win ? p1_wdata : p0_wdata;
          mem_wstrb  <= win ? p1_wstrb : p0_wstrb;
          grant      <= win;
          last_grant <= win;
          mem_req    <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          mem_req <= 1'b0;
          if (mem_ready) begin
            p0_ready <= !grant;
            p1_ready <= grant;
            if (!mem_wen && grant) p1_rdata <= mem_rdata;
            if (!mem_wen && !grant) p0_rdata <= mem_rdata;
            state <= DONE;
          end
        end
        DONE: begin
          p0_ready <= 1'b0;
          p1_ready <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          mem_req  <= 1'b0;
          p0_ready <= 1'b0;
          p1_ready <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter in round-robin (inst 0) and fixed-priority (inst 1) modes
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        p0_req = 1'b0, p1_req = 1'b0, p0_wen = 1'b0, p1_wen = 1'b0;
  logic [31:0] p0_addr = '0, p1_addr = '0, p0_wdata = '0, p1_wdata = '0;
  logic [3:0]  p0_wstrb = '0, p1_wstrb = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0, mem_busy = 1'b0;
  logic        mem_req_o [2], mem_wen_o [2], grant_o [2], busy_o [2], p0_ready_o [2], p1_ready_o [2];
  logic [31:0] mem_addr_o [2], mem_wdata_o [2], p0_rdata_o [2], p1_rdata_o [2];
  logic [3:0]  mem_wstrb_o [2];
  int          checks = 0, fails = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 2; m++) begin : g_dut
    mem_arbiter #(.PRIORITY_MODE(m)) dut (
      .clk(clk), .rstn(rstn),
      .p0_req(p0_req), .p1_req(p1_req), .p0_wen(p0_wen), .p1_wen(p1_wen),
      .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
      .p0_wstrb(p0_wstrb), .p1_wstrb(p1_wstrb),
      .p0_rdata(p0_rdata_o[m]), .p1_rdata(p1_rdata_o[m]),
      .p0_ready(p0_ready_o[m]), .p1_ready(p1_ready_o[m]),
      .mem_req(mem_req_o[m]), .mem_wen(mem_wen_o[m]), .mem_addr(mem_addr_o[m]),
      .mem_wdata(mem_wdata_o[m]), .mem_wstrb(mem_wstrb_o[m]),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_busy(mem_busy),
      .grant(grant_o[m]), .arb_busy(busy_o[m])
    );
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    {p0_req, p1_req, p0_wen, p1_wen, mem_ready, mem_busy} = '0;
    {p0_addr, p1_addr, p0_wdata, p1_wdata, p0_wstrb, p1_wstrb, mem_rdata} = '0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_req(input int s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = mem_req_o[s];
    end
  endtask

  task automatic run_xact(input int s, input logic [31:0] rd, output bit ok, output logic g, output logic w,
                          output logic [31:0] a, output logic [31:0] wd, output logic [3:0] st,
                          output logic rdy0, output logic rdy1, output logic [31:0] r0, output logic [31:0] r1);
    wait_req(s, ok);
    g = grant_o[s]; w = mem_wen_o[s]; a = mem_addr_o[s]; wd = mem_wdata_o[s]; st = mem_wstrb_o[s];
    if (!ok) return;
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ready = 1'b0;
    rdy0 = p0_ready_o[s]; rdy1 = p1_ready_o[s]; r0 = p0_rdata_o[s]; r1 = p1_rdata_o[s];
  endtask

  task automatic test_reset();
    do_reset();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({mem_req_o[m], mem_wen_o[m], grant_o[m], busy_o[m], p0_ready_o[m], p1_ready_o[m]} !== 6'b0) begin
        fails++;
        $display("FAIL reset_ctrl inst %0d got %b want 000000", m,
                 {mem_req_o[m], mem_wen_o[m], grant_o[m], busy_o[m], p0_ready_o[m], p1_ready_o[m]});
      end
      checks++;
      if ({mem_addr_o[m], mem_wdata_o[m], mem_wstrb_o[m], p0_rdata_o[m], p1_rdata_o[m]} !== 132'b0) begin
        fails++;
        $display("FAIL reset_data inst %0d got %h want 0", m,
                 {mem_addr_o[m], mem_wdata_o[m], mem_wstrb_o[m], p0_rdata_o[m], p1_rdata_o[m]});
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 32'h100;
    @(negedge clk);
    checks++;
    if ({mem_req_o[0], mem_wen_o[0], grant_o[0], busy_o[0], mem_addr_o[0]} !== {4'b1001, 32'h100}) begin
      fails++;
      $display("FAIL single_issue got req/wen/grant/busy/addr %b/%b/%b/%b/%h want 1/0/0/1/100",
               mem_req_o[0], mem_wen_o[0], grant_o[0], busy_o[0], mem_addr_o[0]);
    end
    @(negedge clk);
    checks++;
    if (mem_req_o[0] !== 1'b0) begin fails++; $display("FAIL single_pulse got mem_req %b want 0", mem_req_o[0]); end
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ready = 1'b0; p0_req = 1'b0;
    checks++;
    if ({p0_ready_o[0], p1_ready_o[0], p0_rdata_o[0]} !== {2'b10, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL single_done got p0_ready/p1_ready/p0_rdata %b/%b/%h want 1/0/deadbeef",
               p0_ready_o[0], p1_ready_o[0], p0_rdata_o[0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req_o[0], p0_ready_o[0], p1_ready_o[0], busy_o[0]} !== 4'b0) begin
        fails++;
        $display("FAIL single_after got req/p0r/p1r/busy %b want 0000",
                 {mem_req_o[0], p0_ready_o[0], p1_ready_o[0], busy_o[0]});
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok; logic g, w, r0y, r1y, eg; logic [31:0] a, wd, r0, r1; logic [3:0] st;
    do_reset();
    p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 32'h0;
    p1_req = 1'b1; p1_wen = 1'b1; p1_addr = 32'h200; p1_wdata = 32'h12345678; p1_wstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      eg = i[0];
      run_xact(0, 32'hA5A50000 + 32'(i), ok, g, w, a, wd, st, r0y, r1y, r0, r1);
      checks++;
      if (!ok) begin fails++; $display("FAIL rr_timeout xact %0d got no mem_req want mem_req", i); continue; end
      checks++;
      if (g !== eg) begin fails++; $display("FAIL rr_grant xact %0d got %b want %b", i, g, eg); end
      checks++;
      if ({r0y, r1y} !== {!eg, eg}) begin fails++; $display("FAIL rr_ready xact %0d got %b%b want %b%b", i, r0y, r1y, !eg, eg); end
      checks++;
      if (eg && {w, a, wd, st, r1} !== {1'b1, 32'h200, 32'h12345678, 4'hF, 32'h0}) begin
        fails++;
        $display("FAIL rr_write xact %0d got wen/addr/wdata/strb/p1_rdata %b/%h/%h/%h/%h want 1/200/12345678/f/0", i, w, a, wd, st, r1);
      end
      if (!eg && {w, a, r0} !== {1'b0, 32'h0, 32'hA5A50000 + 32'(i)}) begin
        fails++;
        $display("FAIL rr_read xact %0d got wen/addr/p0_rdata %b/%h/%h want 0/0/%h", i, w, a, r0, 32'hA5A50000 + 32'(i));
      end
    end
  endtask

  task automatic test_fixed_priority();
    bit ok; logic g, w, r0y, r1y; logic [31:0] a, wd, r0, r1; logic [3:0] st;
    do_reset();
    p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 32'h40;
    p1_req = 1'b1; p1_wen = 1'b1; p1_addr = 32'h80; p1_wdata = 32'h55AA55AA; p1_wstrb = 4'h3;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) p0_req = 1'b0;
      run_xact(1, 32'h0F0F0000 + 32'(i), ok, g, w, a, wd, st, r0y, r1y, r0, r1);
      checks++;
      if (!ok) begin fails++; $display("FAIL fp_timeout xact %0d got no mem_req want mem_req", i); continue; end
      checks++;
      if ({g, r0y, r1y} !== ((i == 3) ? 3'b101 : 3'b010)) begin
        fails++;
        $display("FAIL fp_grant xact %0d got grant/p0r/p1r %b want %b", i, {g, r0y, r1y}, (i == 3) ? 3'b101 : 3'b010);
      end
    end
  endtask

  task automatic test_busy();
    do_reset();
    mem_busy = 1'b1; p1_req = 1'b1; p1_wen = 1'b0; p1_addr = 32'h300;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req_o[0] !== 1'b0) begin fails++; $display("FAIL busy_block cycle %0d got mem_req %b want 0", i, mem_req_o[0]); end
    end
    mem_busy = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req_o[0], grant_o[0], mem_addr_o[0]} !== {2'b11, 32'h300}) begin
      fails++;
      $display("FAIL busy_release got req/grant/addr %b/%b/%h want 1/1/300", mem_req_o[0], grant_o[0], mem_addr_o[0]);
    end
  endtask

  task automatic test_async_reset();
    bit ok; logic g, w, r0y, r1y; logic [31:0] a, wd, r0, r1; logic [3:0] st;
    do_reset();
    p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 32'h40;
    wait_req(0, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL ar_issue got no mem_req want mem_req"); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({mem_req_o[0], busy_o[0], mem_addr_o[0]} !== 34'b0) begin
      fails++;
      $display("FAIL ar_clear got req/busy/addr %b/%b/%h want 0/0/0", mem_req_o[0], busy_o[0], mem_addr_o[0]);
    end
    p0_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({p0_ready_o[0], p0_rdata_o[0]} !== 33'b0) begin
      fails++;
      $display("FAIL ar_noready got p0_ready/p0_rdata %b/%h want 0/0", p0_ready_o[0], p0_rdata_o[0]);
    end
    rstn = 1'b1;
    p0_req = 1'b1; p0_addr = 32'h44; p1_req = 1'b1; p1_wen = 1'b0; p1_addr = 32'h48;
    run_xact(0, 32'hCAFEF00D, ok, g, w, a, wd, st, r0y, r1y, r0, r1);
    checks++;
    if (!ok || {g, a, r0y, r1y, r0} !== {1'b0, 32'h44, 2'b10, 32'hCAFEF00D}) begin
      fails++;
      $display("FAIL ar_after ok %0d got grant/addr/p0r/p1r/p0_rdata %b/%h/%b/%b/%h want 0/44/1/0/cafef00d", ok, g, a, r0y, r1y, r0);
    end
  endtask

  task automatic test_churn();
    bit ok;
    do_reset();
    p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 32'h10;
    wait_req(0, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL churn_issue got no mem_req want mem_req"); end
    for (int i = 0; i < 3; i++) begin
      p0_addr = 32'h20 + 32'(i); p0_wen = 1'b1; p0_wdata = 32'hFFFF0000;
      @(negedge clk);
      checks++;
      if ({mem_addr_o[0], mem_wen_o[0], mem_wdata_o[0]} !== {32'h10, 1'b0, 32'h0}) begin
        fails++;
        $display("FAIL churn_hold cycle %0d got addr/wen/wdata %h/%b/%h want 10/0/0", i, mem_addr_o[0], mem_wen_o[0], mem_wdata_o[0]);
      end
    end
    mem_ready = 1'b1; mem_rdata = 32'h77;
    @(negedge clk);
    mem_ready = 1'b0; p0_req = 1'b0;
    checks++;
    if ({p0_ready_o[0], p0_rdata_o[0], mem_addr_o[0]} !== {1'b1, 32'h77, 32'h10}) begin
      fails++;
      $display("FAIL churn_done got p0_ready/p0_rdata/addr %b/%h/%h want 1/77/10", p0_ready_o[0], p0_rdata_o[0], mem_addr_o[0]);
    end
  endtask

  task automatic test_random(input int s);
    bit pend [2]; bit free, cool, exp_iss, rp; int mc;
    logic last, ow, ew, e_wen; logic [31:0] e_addr, e_wdata, ret; logic [3:0] e_strb;
    logic [31:0] exp_rd [2]; logic rq_wen [2]; logic [31:0] rq_addr [2], rq_wdata [2]; logic [3:0] rq_strb [2];
    do_reset();
    pend = '{1'b0, 1'b0}; exp_rd = '{32'h0, 32'h0};
    rq_wen = '{1'b0, 1'b0}; rq_addr = '{32'h0, 32'h0}; rq_wdata = '{32'h0, 32'h0}; rq_strb = '{4'h0, 4'h0};
    free = 1'b1; cool = 1'b0; exp_iss = 1'b0; rp = 1'b0; mc = 0;
    last = 1'b1; ow = 1'b0; ew = 1'b0; e_wen = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0; ret = '0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (cool) begin free = 1'b1; cool = 1'b0; end
      checks++;
      if (mem_req_o[s] !== exp_iss) begin fails++; $display("FAIL rnd_req mode %0d cycle %0d got %b want %b", s, t, mem_req_o[s], exp_iss); end
      if (exp_iss) begin
        checks++;
        if ({grant_o[s], mem_wen_o[s], mem_addr_o[s], mem_wdata_o[s], mem_wstrb_o[s]} !== {ew, e_wen, e_addr, e_wdata, e_strb}) begin
          fails++;
          $display("FAIL rnd_fields mode %0d cycle %0d got grant/wen/addr/wdata/strb %b/%b/%h/%h/%h want %b/%b/%h/%h/%h", s, t,
                   grant_o[s], mem_wen_o[s], mem_addr_o[s], mem_wdata_o[s], mem_wstrb_o[s], ew, e_wen, e_addr, e_wdata, e_strb);
        end
        mc = $urandom_range(1, 4);
      end else if (!free) begin
        checks++;
        if ({grant_o[s], mem_addr_o[s]} !== {ow, e_addr}) begin
          fails++;
          $display("FAIL rnd_hold mode %0d cycle %0d got grant/addr %b/%h want %b/%h", s, t, grant_o[s], mem_addr_o[s], ow, e_addr);
        end
      end
      checks++;
      if ({p0_ready_o[s], p1_ready_o[s]} !== {rp && !ow, rp && ow}) begin
        fails++;
        $display("FAIL rnd_ready mode %0d cycle %0d got %b%b want %b%b", s, t, p0_ready_o[s], p1_ready_o[s], rp && !ow, rp && ow);
      end
      if (rp) begin
        if (!e_wen) exp_rd[ow] = ret;
        pend[ow] = 1'b0;
        cool = 1'b1;
      end
      checks++;
      if ({p0_rdata_o[s], p1_rdata_o[s]} !== {exp_rd[0], exp_rd[1]}) begin
        fails++;
        $display("FAIL rnd_rdata mode %0d cycle %0d got %h/%h want %h/%h", s, t, p0_rdata_o[s], p1_rdata_o[s], exp_rd[0], exp_rd[1]);
      end
      exp_iss = 1'b0; rp = 1'b0;
      mem_ready = 1'b0; mem_rdata = $urandom;
      if (mc > 0) begin
        mc--;
        if (mc == 0) begin ret = $urandom; mem_rdata = ret; mem_ready = 1'b1; rp = 1'b1; end
      end
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1; rq_wen[p] = 1'($urandom); rq_addr[p] = $urandom; rq_wdata[p] = $urandom; rq_strb[p] = 4'($urandom);
        end
      if (!free && !cool && $urandom_range(0, 1) == 1) rq_addr[ow] = $urandom;
      p0_req = pend[0]; p0_wen = rq_wen[0]; p0_addr = rq_addr[0]; p0_wdata = rq_wdata[0]; p0_wstrb = rq_strb[0];
      p1_req = pend[1]; p1_wen = rq_wen[1]; p1_addr = rq_addr[1]; p1_wdata = rq_wdata[1]; p1_wstrb = rq_strb[1];
      mem_busy = ($urandom_range(0, 3) == 0);
      if (free && (pend[0] || pend[1]) && !mem_busy) begin
        ew = (s == 1) ? !pend[0] : ((pend[0] && pend[1]) ? !last : pend[1]);
        last = ew; ow = ew; free = 1'b0; exp_iss = 1'b1;
        e_wen = rq_wen[ew]; e_addr = rq_addr[ew]; e_wdata = rq_wdata[ew]; e_strb = rq_strb[ew];
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_busy();
    test_async_reset();
    test_churn();
    test_random(0);
    test_random(1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one simple memory request interface (`mem_req`/`mem_wen`/`mem_addr`/…/`mem_ready`/`mem_busy`) of the core's AXI-Lite master between the instruction-fetch port (port 0) and the load/store port (port 1). Each requester holds a level request until it receives a one-cycle ready pulse. The arbiter selects one requester, issues a single-cycle `mem_req` to the master, and routes the completion back. It sits between the control unit and `axil_master`.

## Interface
- `DATA_WIDTH`, 32: data bus width.
- `ADDR_WIDTH`, 32: address width.
- `STRB_WIDTH`, DATA_WIDTH/8: byte-strobe width.
- `PRIORITY_MODE`, 0: 0 = round-robin; 1 = fixed priority, port 0 always wins.
- `clk`  in  1  clock; one clock domain.
- `rstn`  in  1  reset, asynchronous, active-low.
- `p0_req`, `p1_req`  in  1  level request, held until the matching `pN_ready`.
- `p0_wen`, `p1_wen`  in  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  ADDR_WIDTH  address.
- `p0_wdata`, `p1_wdata`  in  DATA_WIDTH  write data.
- `p0_wstrb`, `p1_wstrb`  in  STRB_WIDTH  write strobes.
- `p0_rdata`, `p1_rdata`  out  DATA_WIDTH  registered read data.
- `p0_ready`, `p1_ready`  out  1  one-cycle completion pulse.
- `mem_req`  out  1  one-cycle request pulse to the master.
- `mem_wen`  out  1  forwarded write enable.
- `mem_addr`  out  ADDR_WIDTH  forwarded address.
- `mem_wdata`  out  DATA_WIDTH  forwarded write data.
- `mem_wstrb`  out  STRB_WIDTH  forwarded strobes.
- `mem_rdata`  in  DATA_WIDTH  read data from the master.
- `mem_ready`  in  1  completion pulse from the master.
- `mem_busy`  in  1  master is not idle.
- `grant`  out  1  index of the port owning the current or last transaction.
- `arb_busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WAIT, DONE.
- **IDLE**
  - Entered when (p0_req|p1_req) && !mem_busy.
  - Choose the winner, latch its wen/addr/wdata/wstrb into the `mem_*` outputs, set `grant`, set `mem_req`=1, go to WAIT.
  - Otherwise stay in IDLE.
- **Arbitration**
  - PRIORITY_MODE=0: if both ports request, the port ≠ `last_grant` wins. `last_grant` resets to 1, so port 0 wins the first tie.
  - If only one port requests, it wins.
  - `last_grant` updates to the winner on each issue.
  - PRIORITY_MODE=1: port 0 wins whenever `p0_req` is high.
- **WAIT**
  - `mem_req` is cleared after exactly one cycle.
  - `mem_*` forward outputs are held stable.
  - Requester inputs are ignored; changes on them have no effect.
  - On `mem_ready`: assert `p[grant]_ready`=1. If the latched wen=0, load `p[grant]_rdata` ← `mem_rdata`; on writes `rdata` keeps its prior value. Go to DONE.
- **DONE**
  - `pN_ready` is high for this single cycle, then cleared.
  - Go to IDLE.
  - The requester drops (or changes) `req` at the edge where it sees ready, so IDLE samples the updated request.
- The non-granted `pN_ready` is never asserted. At most one `pN_ready` is high in any cycle.
- Unreachable state encodings return to IDLE.

## Timing
- **Reset values:** state IDLE; `mem_req`, `mem_wen`, `p0_ready`, `p1_ready`, `grant`, `arb_busy` = 0; `mem_addr`, `mem_wdata`, `mem_wstrb`, `p0_rdata`, `p1_rdata` = 0; `last_grant` = 1.
- **Issue latency:**
  - Request sampled high at edge k with the arbiter idle: `mem_req` is high during cycle k..k+1.
  - The master samples it at edge k+1.
- **Completion latency:**
  - `mem_ready` sampled at edge m: `pN_ready` and `rdata` are valid during cycle m..m+1.
  - IDLE is re-entered at edge m+1.
  - The next issue is no earlier than edge m+2.
- **Back-to-back:** the minimum arbiter overhead is 3 cycles per transaction beyond master latency (issue + ready + re-arbitrate).
- **Busy interlock:** `mem_busy` high in IDLE blocks issue indefinitely. No request is lost; it stays pending as a level.
- **Async reset:** asserting `rstn` low mid-WAIT or mid-DONE clears all outputs immediately. No ready pulse is generated for the aborted transaction. The master shares `rstn` and is reset concurrently.
- **Both ports hold `req` continuously (round-robin):** grants alternate 0,1,0,1… with no starvation.

## Test plan
- **Single read, port 0:** `p0_req`=1, addr 0x100, master returns 0xDEADBEEF → exactly one `mem_req` pulse with `mem_addr`=0x100, `mem_wen`=0; `p0_ready` pulse with `p0_rdata`=0xDEADBEEF; `p1_ready` stays 0.
- **Simultaneous requests, PRIORITY_MODE=0, held for 4 transactions:** port 0 read 0x0 and port 1 write 0x200/0x12345678/strb 0xF → grant order 0,1,0,1; write forwards `wdata`=0x12345678, `wstrb`=0xF; `p1_rdata` is unchanged by the write.
- **Fixed priority (PRIORITY_MODE=1):** both requesting continuously → every grant goes to port 0; port 1 is served only after `p0_req` drops.
- **`mem_busy` held high 5 cycles while `p1_req`=1:** no `mem_req` during those cycles; `mem_req` pulses on the first idle cycle after `mem_busy` falls.
- **Async reset mid-WAIT:** port 0 read issued, `rstn` low before `mem_ready` → outputs are 0 immediately, no `p0_ready`; after release, a fresh request completes normally with port 0 winning the first tie.
- **Input churn during WAIT:** change `p0_addr` from 0x10 to 0x20 during WAIT → `mem_addr` stays 0x10 until completion.
